// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller (collect, dispense, change, timeout refund)
// Ports:
//   clk       in   clock, all state changes on rising edge
//   rstn      in   asynchronous active-low reset
//   a         in   2-unit coin pulse
//   b         in   1-unit coin pulse
//   cancel    in   refund request (level)
//   disp_ack  in   dispenser delivered the item
//   disp_req  out  dispense request, high in DISPENSE
//   chg       out  1-unit change pulse per high cycle
//   rej       out  coin rejected (coin arriving in DISPENSE or CHANGE)
//   busy      out  high in every state except IDLE
//   credit    out  current credit
module vend_ctrl #(
    parameter int PRICE   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       a,
    input  logic       b,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       chg,
    output logic       rej,
    output logic       busy,
    output logic [2:0] credit
);
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
    localparam logic [2:0] P = 3'(PRICE);
    localparam logic [7:0] T = 8'(TIMEOUT - 1);
    state_t     r_state;
    logic [2:0] r_credit;
    logic [7:0] r_idle;
    logic       w_coin;
    logic [2:0] w_cin;
    logic       w_paid;
    // coin value 2*a + b is exactly the two-bit vector {a,b}
    assign w_coin = a | b;
    assign w_cin  = r_credit + {1'b0, a, b};
    assign w_paid = w_cin >= P;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_credit <= 3'd0;
            r_idle   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idle <= 8'd0;
                    if (w_coin) begin
                        r_credit <= w_cin;
                        r_state  <= w_paid ? DISPENSE : COLLECT;
                    end
                end
                COLLECT: begin
                    // a coin always wins over cancel; reaching the price also overrides cancel
                    if (w_coin) begin
                        r_credit <= w_cin;
                        r_idle   <= 8'd0;
                        r_state  <= w_paid ? DISPENSE : (cancel ? CHANGE : COLLECT);
                    end else if (cancel || r_idle == T) begin
                        r_idle  <= 8'd0;
                        r_state <= CHANGE;
                    end else begin
                        r_idle <= r_idle + 8'd1;
                    end
                end
                DISPENSE: begin
                    if (disp_ack) begin
                        r_credit <= r_credit - P;
                        r_state  <= (r_credit == P) ? IDLE : CHANGE;
                    end
                end
                CHANGE: begin
                    r_credit <= r_credit - 3'd1;
                    if (r_credit == 3'd1) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign disp_req = r_state == DISPENSE;
    assign chg      = r_state == CHANGE;
    assign busy     = r_state != IDLE;
    assign rej      = w_coin && (r_state == DISPENSE || r_state == CHANGE);
    assign credit   = r_credit;
endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 3, item price in credit units; legal range 1..5.
REQ-002 Parameter TIMEOUT, default 15, idle cycles allowed in COLLECT before auto-refund; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 a  input  1  2-unit coin accepted this cycle, one-cycle pulse.
REQ-006 b  input  1  1-unit coin accepted this cycle, one-cycle pulse.
REQ-007 cancel  input  1  customer refund request, level, sampled each cycle.
REQ-008 disp_ack  input  1  dispenser has delivered the item.
REQ-009 disp_req  output  1  dispense request, high throughout DISPENSE.
REQ-010 chg  output  1  1-unit change pulse, one unit per high cycle.
REQ-011 rej  output  1  coin rejected this cycle; mechanism must return it.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 credit  output  3  current credit register value.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, COLLECT, DISPENSE, CHANGE.
REQ-015 Coin value SHALL be 2*a + b; a and b high together add 3.
REQ-016 In IDLE or COLLECT, a coin SHALL be added as cin = credit + coin value, 3-bit, with no overflow possible within the legal PRICE range.
REQ-017 In IDLE or COLLECT, cin >= PRICE SHALL give next state DISPENSE, credit <= cin.
REQ-018 In IDLE or COLLECT, 0 < cin < PRICE SHALL give next state COLLECT, credit <= cin.
REQ-019 In IDLE, cancel SHALL be ignored and absence of a coin SHALL keep IDLE.
REQ-020 In COLLECT, an 8-bit idle counter SHALL clear on entry and on every coin, and SHALL increment otherwise.
REQ-021 In COLLECT, the idle counter reaching TIMEOUT-1 on a cycle with no coin SHALL move to CHANGE, credit unchanged.
REQ-022 In COLLECT, cancel with no coin SHALL move to CHANGE next cycle.
REQ-023 In COLLECT, cancel with a coin SHALL add the coin first; if cin >= PRICE go to DISPENSE with cancel ignored, else go to CHANGE with credit <= cin.
REQ-024 In DISPENSE, disp_req SHALL be 1, and cancel and timeout SHALL be ignored.
REQ-025 In DISPENSE, disp_ack sampled high SHALL set credit <= credit - PRICE and go to CHANGE if the result is > 0, else to IDLE.
REQ-026 In DISPENSE, disp_ack low SHALL hold state and credit indefinitely.
REQ-027 In CHANGE, chg SHALL be 1 and credit SHALL decrement by 1 each cycle; credit reaching 0 gives IDLE.
REQ-028 CHANGE SHALL never be entered with credit 0, so exactly credit chg pulses are emitted per visit.
REQ-029 rej SHALL be combinational: (a|b) while in DISPENSE or CHANGE; rejected coins never alter credit.
REQ-030 disp_req, chg and busy SHALL be Moore outputs decoded from the state register only.
REQ-031 disp_ack outside DISPENSE SHALL be ignored.
REQ-032 Latency: a coin sampled at edge k SHALL show the updated credit and disp_req after edge k.

Reset
REQ-033 rstn low SHALL immediately force state IDLE, credit 0, idle counter 0, and disp_req, chg, busy to 0, rej to 0 absent coins, regardless of clock.
REQ-034 Reset mid-DISPENSE or mid-CHANGE SHALL abandon the transaction; no refund is owed after release.
REQ-035 The first edge after rstn rises SHALL behave as normal IDLE operation.

Verification
REQ-036 PRICE=3: b, b, b on consecutive cycles -> credit 1,2,3; disp_req high after third edge; disp_ack -> IDLE, no chg.
REQ-037 PRICE=3: a, a -> credit 4, DISPENSE; disp_ack -> CHANGE, exactly 1 chg cycle, then IDLE, busy 0.
REQ-038 PRICE=3: a and b same cycle -> credit 3, DISPENSE; a during DISPENSE -> rej=1 that cycle, credit stays 3.
REQ-039 PRICE=3: a, then cancel -> CHANGE, 2 chg cycles, IDLE; b with cancel from credit 0 -> 1 chg pulse.
REQ-040 TIMEOUT=15: b then no input -> CHANGE entered exactly 15 cycles after the coin edge, 1 chg pulse.
REQ-041 Assert rstn low during CHANGE with credit 2 -> outputs 0 at once, credit 0; after release, chg stays 0.
